// File: rtl/fifo_block_accumulator.sv
// Block-sum stage behind the AHB slave: buffers pushed words, sums fixed-length
// blocks (32-bit wrap) into an output FIFO, and exposes control/status registers.
module fifo_block_accumulator #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wrreq,
  input  logic [31:0] wdata,
  output logic        wrfull,
  input  logic        rdack,
  output logic [31:0] rdata,
  output logic        rdempty,
  input  logic        u_write,
  input  logic [31:0] u_addr,
  input  logic [31:0] u_wdata,
  output logic [31:0] u_data
);

  localparam int AW = CW - 1;

  typedef enum logic [1:0] {IDLE, ACCUM, PUSH} state_t;

  logic [31:0]   in_mem  [DEPTH];
  logic [31:0]   out_mem [DEPTH];
  logic [AW-1:0] in_wp, in_rp, out_wp, out_rp;
  logic [CW-1:0] in_count, out_count;
  logic          wrfull_q;
  logic [31:0]   rdata_q;

  logic          ctrl_en;
  logic [15:0]   block_len;
  logic [7:0]    ovf;
  logic [31:0]   blocks;

  state_t        state;
  logic [15:0]   len_q, cnt;
  logic [31:0]   acc;

  logic [7:0]    reg_sel;
  logic          wr_ctrl, wr_len, clear;
  logic          in_full, in_push, in_ovf, in_pop;
  logic          out_full, out_push, out_pop;
  logic [CW-1:0] in_count_nxt, out_count_nxt, out_remain;
  logic [AW-1:0] out_rp_nxt;
  logic [31:0]   status;
  logic          unused_bits;

  assign reg_sel = u_addr[7:0];
  assign wr_ctrl = u_write && (reg_sel == 8'h00);
  assign wr_len  = u_write && (reg_sel == 8'h04);
  assign clear   = wr_ctrl && u_wdata[1];

  // Overflow is judged on the pre-edge count, so a same-cycle pop never rescues a word.
  assign in_full  = (in_count == CW'(DEPTH));
  assign in_push  = wrreq && !in_full && !clear;
  assign in_ovf   = wrreq && in_full && !clear;
  assign in_pop   = (state == ACCUM) && (in_count != '0) && !clear;

  assign out_full = (out_count == CW'(DEPTH));
  assign out_push = (state == PUSH) && !out_full && !clear;
  assign out_pop  = rdack && (out_count != '0) && !clear;

  assign in_count_nxt  = in_count + CW'(in_push) - CW'(in_pop);
  assign out_count_nxt = out_count + CW'(out_push) - CW'(out_pop);
  assign out_remain    = out_count - CW'(out_pop);
  assign out_rp_nxt    = out_rp + AW'(out_pop);

  assign wrfull  = wrfull_q;
  assign rdata   = rdata_q;
  assign rdempty = (out_count == '0);

  assign unused_bits = ^{u_addr[31:8], u_wdata[31:16]};

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wp]   <= wdata;
    if (out_push) out_mem[out_wp] <= acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_wp     <= '0;
      in_rp     <= '0;
      out_wp    <= '0;
      out_rp    <= '0;
      in_count  <= '0;
      out_count <= '0;
      wrfull_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_en   <= 1'b0;
      block_len <= 16'd1;
      ovf       <= '0;
      blocks    <= '0;
      state     <= IDLE;
      len_q     <= 16'd1;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      if (wr_ctrl) ctrl_en   <= u_wdata[0];
      if (wr_len)  block_len <= u_wdata[15:0];

      if (clear) begin
        in_wp     <= '0;
        in_rp     <= '0;
        out_wp    <= '0;
        out_rp    <= '0;
        in_count  <= '0;
        out_count <= '0;
        wrfull_q  <= 1'b0;
        ovf       <= '0;
        blocks    <= '0;
        state     <= IDLE;
        cnt       <= '0;
        acc       <= '0;
      end else begin
        if (in_push)  in_wp  <= in_wp + 1'b1;
        if (in_pop)   in_rp  <= in_rp + 1'b1;
        if (out_push) out_wp <= out_wp + 1'b1;
        out_rp    <= out_rp_nxt;
        in_count  <= in_count_nxt;
        out_count <= out_count_nxt;
        wrfull_q  <= (in_count_nxt == CW'(DEPTH));
        if (in_ovf && ovf != 8'hFF) ovf <= ovf + 8'd1;

        // Show-ahead head register: next stored entry, else a word entering an empty FIFO, else hold.
        if (out_remain != '0) rdata_q <= out_mem[out_rp_nxt];
        else if (out_push)    rdata_q <= acc;

        case (state)
          IDLE: begin
            if (ctrl_en && in_count != '0) begin
              len_q <= (block_len == 16'd0) ? 16'd1 : block_len;
              acc   <= '0;
              cnt   <= '0;
              state <= ACCUM;
            end
          end
          ACCUM: begin
            if (in_pop) begin
              acc <= acc + in_mem[in_rp];
              cnt <= cnt + 16'd1;
              if (cnt + 16'd1 == len_q) state <= PUSH;
            end
          end
          PUSH: begin
            if (!out_full) begin
              blocks <= blocks + 32'd1;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    status           = '0;
    status[CW-1:0]   = in_count;
    status[8 +: CW]  = out_count;
    status[16]       = (state != IDLE);
    status[31:24]    = ovf;
  end

  always_comb begin
    u_data = '0;
    case (reg_sel)
      8'h00:   u_data = {31'd0, ctrl_en};
      8'h04:   u_data = {16'd0, block_len};
      8'h08:   u_data = status;
      8'h0C:   u_data = blocks;
      default: u_data = '0;
    endcase
  end

endmodule

// File: tb/tb_fifo_block_accumulator.sv
// Scoreboard bench for fifo_block_accumulator: expected block sums are queued as
// words are pushed and popped/compared as the output FIFO delivers them.
module tb_fifo_block_accumulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wrreq = 1'b0;
  logic [31:0] wdata = '0;
  logic        wrfull;
  logic        rdack = 1'b0;
  logic [31:0] rdata;
  logic        rdempty;
  logic        u_write = 1'b0;
  logic [31:0] u_addr = '0;
  logic [31:0] u_wdata = '0;
  logic [31:0] u_data;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];

  fifo_block_accumulator #(.DEPTH(16), .CW(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .wrreq(wrreq), .wdata(wdata), .wrfull(wrfull),
    .rdack(rdack), .rdata(rdata), .rdempty(rdempty),
    .u_write(u_write), .u_addr(u_addr), .u_wdata(u_wdata), .u_data(u_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    u_addr = {24'h0, a}; u_wdata = d; u_write = 1'b1;
    @(posedge clk); #1;
    u_write = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    u_addr = {24'h0, a};
    #1;
    d = u_data;
  endtask

  task automatic push_word(input logic [31:0] w);
    wrreq = 1'b1; wdata = w;
    @(posedge clk); #1;
    wrreq = 1'b0;
  endtask

  task automatic pop_output(output logic [31:0] w, output bit ok);
    int n = 0;
    while (rdempty && n < 200) begin @(posedge clk); #1; n++; end
    ok = !rdempty;
    w  = rdata;
    if (ok) begin
      rdack = 1'b1;
      @(posedge clk); #1;
      rdack = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_n = 1'b0;
    tick(2);
    vectors++; if (rdempty !== 1'b1) begin miscompares++; $display("FAIL reset_rdempty: got %b want 1", rdempty); end
    vectors++; if (wrfull !== 1'b0) begin miscompares++; $display("FAIL reset_wrfull: got %b want 0", wrfull); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    reg_read(8'h04, r);
    vectors++; if (r !== 32'h1) begin miscompares++; $display("FAIL reset_block_len: got %h want 1", r); end
    reg_read(8'h08, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h want 0", r); end
    reg_read(8'h00, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h want 0", r); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_basic_sum();
    logic [31:0] got, r, exp;
    bit ok;
    reg_write(8'h04, 32'd4);
    reg_write(8'h00, 32'd1);
    for (int i = 1; i <= 4; i++) push_word(32'(i));
    sb.push_back(32'd10);
    pop_output(got, ok);
    exp = sb.pop_front();
    vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL basic_sum: got %h ok=%0d want %h", got, ok, exp); end
    vectors++; if (rdempty !== 1'b1) begin miscompares++; $display("FAIL basic_rdempty_after_pop: got %b want 1", rdempty); end
    reg_read(8'h0C, r);
    vectors++; if (r !== 32'd1) begin miscompares++; $display("FAIL basic_blocks: got %0d want 1", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] got, r, exp, sum;
    bit ok;
    reg_write(8'h00, 32'h2);
    sum = '0;
    for (int i = 0; i < 17; i++) begin
      push_word(32'(i * 3 + 1));
      if (i < 16) sum += 32'(i * 3 + 1);
      if (i == 14) begin
        vectors++; if (wrfull !== 1'b0) begin miscompares++; $display("FAIL ovf_wrfull_15: got %b want 0", wrfull); end
      end
      if (i == 15) begin
        vectors++; if (wrfull !== 1'b1) begin miscompares++; $display("FAIL ovf_wrfull_16: got %b want 1", wrfull); end
      end
    end
    reg_read(8'h08, r);
    vectors++; if (r !== 32'h0100_0010) begin miscompares++; $display("FAIL ovf_status: got %h want 01000010", r); end
    reg_write(8'h04, 32'd16);
    reg_write(8'h00, 32'd1);
    sb.push_back(sum);
    pop_output(got, ok);
    exp = sb.pop_front();
    vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL ovf_sum16: got %h ok=%0d want %h", got, ok, exp); end
  endtask

  task automatic test_wrap();
    logic [31:0] got, exp;
    bit ok;
    reg_write(8'h04, 32'd2);
    push_word(32'hFFFF_FFFF);
    push_word(32'h0000_0002);
    sb.push_back(32'h0000_0001);
    pop_output(got, ok);
    exp = sb.pop_front();
    vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL wrap_sum: got %h ok=%0d want %h", got, ok, exp); end
  endtask

  task automatic test_latency();
    logic [31:0] got, exp;
    bit ok;
    reg_write(8'h00, 32'd0);
    reg_write(8'h04, 32'd3);
    push_word(32'd5); push_word(32'd6); push_word(32'd7);
    tick(2);
    sb.push_back(32'd18);
    reg_write(8'h00, 32'd1);
    tick(4);
    vectors++; if (rdempty !== 1'b1) begin miscompares++; $display("FAIL latency_edge_n1: got rdempty=%b want 1", rdempty); end
    tick(1);
    vectors++; if (rdempty !== 1'b0) begin miscompares++; $display("FAIL latency_edge_n2: got rdempty=%b want 0", rdempty); end
    pop_output(got, ok);
    exp = sb.pop_front();
    vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL latency_sum: got %h ok=%0d want %h", got, ok, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, r, exp;
    bit ok;
    reg_write(8'h00, 32'h3);
    reg_write(8'h04, 32'd1);
    for (int i = 0; i < 17; i++) begin
      push_word(32'(100 + i));
      sb.push_back(32'(100 + i));
    end
    tick(80);
    reg_read(8'h08, r);
    vectors++; if (r[12:8] !== 5'd16) begin miscompares++; $display("FAIL bp_out_count: got %0d want 16", r[12:8]); end
    vectors++; if (r[16] !== 1'b1) begin miscompares++; $display("FAIL bp_busy: got %b want 1", r[16]); end
    vectors++; if (r[4:0] !== 5'd0) begin miscompares++; $display("FAIL bp_in_count: got %0d want 0", r[4:0]); end
    pop_output(got, ok);
    exp = sb.pop_front();
    vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL bp_first: got %h ok=%0d want %h", got, ok, exp); end
    tick(1);
    reg_read(8'h08, r);
    vectors++; if (r[12:8] !== 5'd16 || r[16] !== 1'b0) begin miscompares++; $display("FAIL bp_refill: got out_count=%0d busy=%b want 16/0", r[12:8], r[16]); end
    while (sb.size() > 0) begin
      pop_output(got, ok);
      exp = sb.pop_front();
      vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL bp_drain: got %h ok=%0d want %h", got, ok, exp); end
    end
  endtask

  task automatic test_len0_clear();
    logic [31:0] got, r, exp;
    bit ok;
    reg_write(8'h04, 32'd0);
    push_word(32'd5);
    sb.push_back(32'd5);
    pop_output(got, ok);
    exp = sb.pop_front();
    vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL len0_as_1: got %h ok=%0d want %h", got, ok, exp); end
    reg_write(8'h04, 32'd3);
    push_word(32'd9);
    push_word(32'd9);
    tick(4);
    reg_read(8'h08, r);
    vectors++; if (r[16] !== 1'b1) begin miscompares++; $display("FAIL clear_pre_busy: got %b want 1", r[16]); end
    reg_write(8'h00, 32'h3);
    reg_read(8'h08, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL clear_status: got %h want 0", r); end
    reg_read(8'h0C, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL clear_blocks: got %h want 0", r); end
    vectors++; if (rdempty !== 1'b1) begin miscompares++; $display("FAIL clear_rdempty: got %b want 1", rdempty); end
    reg_read(8'h00, r);
    vectors++; if (r !== 32'h1) begin miscompares++; $display("FAIL clear_ctrl: got %h want 1", r); end
  endtask

  task automatic test_async_reset();
    logic [31:0] got, r, exp;
    bit ok;
    reg_write(8'h04, 32'd1);
    push_word(32'd7);
    tick(5);
    vectors++; if (rdempty !== 1'b0 || rdata !== 32'd7) begin miscompares++; $display("FAIL ar_pre_rdata: got %h empty=%b want 7/0", rdata, rdempty); end
    reg_write(8'h04, 32'd4);
    push_word(32'd1);
    push_word(32'd2);
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (rdempty !== 1'b1 || rdata !== 32'h0 || wrfull !== 1'b0) begin miscompares++; $display("FAIL ar_outputs: got empty=%b rdata=%h full=%b want 1/0/0", rdempty, rdata, wrfull); end
    reg_read(8'h04, r);
    vectors++; if (r !== 32'h1) begin miscompares++; $display("FAIL ar_block_len: got %h want 1", r); end
    reg_read(8'h08, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL ar_status: got %h want 0", r); end
    reg_read(8'h00, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL ar_ctrl: got %h want 0", r); end
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(1);
    reg_write(8'h00, 32'd1);
    push_word(32'd42);
    sb.push_back(32'd42);
    pop_output(got, ok);
    exp = sb.pop_front();
    vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL ar_recover: got %h ok=%0d want %h", got, ok, exp); end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_overflow();
    test_wrap();
    test_latency();
    test_back_to_back();
    test_len0_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
